// File: rtl/result_drain_pkg.sv
// Shared types and helpers for the result_drain block.
// The checksum helper is only referenced when RESULT_DRAIN_CHECKSUM_EN is defined.
package result_drain_pkg;

    localparam int RD_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } drain_state_t;

    // Rotate-left-by-one then XOR in the new word.
    function automatic logic [RD_DATA_W-1:0] checksum_next(
        input logic [RD_DATA_W-1:0] sum,
        input logic [RD_DATA_W-1:0] word
    );
        return {sum[RD_DATA_W-2:0], sum[RD_DATA_W-1]} ^ word;
    endfunction

endpackage

// File: rtl/result_drain_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// rdata reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Equal index with differing wrap bit means the writer lapped the reader.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/result_drain.sv
// Result stream drain: collects an armed number of words into a FIFO and replays them downstream.
// Optional running checksum enabled by defining RESULT_DRAIN_CHECKSUM_EN.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int DATA_W = RD_DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  expected_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              stray,
    output logic [CNT_W-1:0]  word_count,
    output logic [DATA_W-1:0] checksum,
    output drain_state_t      state
);

    // Handshake: a word moves on a rising edge where valid && ready are both high;
    // valid never depends on ready, and ready/valid here depend only on registered state.
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;
    logic [CNT_W-1:0]  expected_q;
    logic [CNT_W-1:0]  word_count_q;
    logic              stray_q;
    logic              done_q;

    assign in_ready   = (state == ST_COLLECT) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign busy       = (state == ST_COLLECT) || (state == ST_FLUSH);
    assign done       = done_q;
    assign stray      = stray_q;
    assign word_count = word_count_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (in_data),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            expected_q   <= '0;
            word_count_q <= '0;
            stray_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            if (in_valid && state != ST_COLLECT) stray_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // An accepted start clears stray even if in_valid is high this cycle.
                    if (start) begin
                        expected_q   <= expected_count;
                        word_count_q <= '0;
                        stray_q      <= 1'b0;
                        state        <= (expected_count == '0) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        word_count_q <= word_count_q + CNT_W'(1);
                        if (word_count_q + CNT_W'(1) == expected_q) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (state == ST_IDLE && start) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_next(checksum_q, in_data);
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/result_drain.md
# result_drain

Output-side responder for the accelerator's result stream: the consuming end of the valid/ready interface whose producing end feeds the accelerator. It accepts an armed number of result words into a small FIFO, re-presents them on a downstream valid/ready port and, optionally, folds them into a running checksum. It sits between the accelerator output and the host/bench readback path, and signals completion once every expected word has been delivered downstream.

## Interface

- DATA_W, 32, result word width
- DEPTH, 8, FIFO depth in words; power of two, ≥2
- CNT_W, 16, width of expected/accepted word counters

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  one-cycle pulse; arms a transfer (ignored unless IDLE)
- expected_count  input  CNT_W  words to accept; sampled when start is accepted
- in_valid  input  1  upstream word valid
- in_data  input  DATA_W  upstream word
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  FIFO head valid
- out_data  output  DATA_W  FIFO head word
- out_ready  input  1  downstream accepts head
- busy  output  1  state is COLLECT or FLUSH
- done  output  1  one-cycle pulse; transfer complete
- stray  output  1  sticky: in_valid seen while not COLLECT; cleared on accepted start
- word_count  output  CNT_W  words accepted this transfer
- checksum  output  DATA_W  running checksum of accepted words

## Operation

- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE: in_ready=0. start → latch expected_count, clear word_count, checksum, stray; go COLLECT, or DONE if expected_count==0.
- COLLECT: in_ready = !fifo_full. Accept = in_valid && in_ready → push, word_count+1, checksum update. Accept making word_count == expected → FLUSH.
- FLUSH: in_ready=0; wait until FIFO empty → DONE.
- DONE: done=1 for one cycle → IDLE.
- FIFO: first-word-fall-through. out_valid = !empty; pop on out_valid && out_ready; pops are allowed in every state.
- Push gated on not-full regardless of a same-cycle pop. Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- Read/write pointers are log2(DEPTH)+1 bits with wrap bit. full/empty are derived from pointer compare.
- start while busy or in DONE: ignored, no state change.
- word_count saturates at expected_count by construction; no counter wrap.
- stray set on any cycle with in_valid=1 in IDLE, FLUSH or DONE.

## Timing

- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, stray=0, word_count=0, checksum=0; state IDLE; FIFO empty.
- start at edge k → COLLECT from k; in_ready may be 1 in cycle k+1.
- Word accepted at edge k → out_valid=1 and out_data valid in cycle k+1 if the FIFO was empty (one-cycle latency).
- Last pop at edge k in FLUSH → state DONE after edge k+1; done high for one cycle. If expected_count==0: done high two cycles after start.
- word_count and checksum reflect accepted words one cycle after each accept. Both hold through DONE/IDLE until the next start.
- Reset mid-transfer: immediate return to reset values; FIFO contents discarded.

## Configuration

- RESULT_DRAIN_CHECKSUM_EN defined: on each accept, checksum ← rotl(checksum,1) ^ in_data.
- Not defined: no checksum logic; checksum output tied to 0.

## Structure

- Shared package: state enum typedef (drain_state_t) and the checksum-update function.
- One sub-module: sync_fifo (parameterised DATA_W/DEPTH, FWFT, full/empty outputs), instantiated once.

## Test plan

- Reset: assert rst mid-COLLECT with 3 words buffered → all outputs at reset values, out_valid=0 the same cycle.
- Basic: expected_count=3, words 0x1,0x2,0x3, out_ready=1 → out_data 1,2,3 in order; word_count=3; checksum=0x00000003 (macro on); done pulse once.
- Backpressure: DEPTH=8, expected_count=12, out_ready=0 → in_ready drops after 8 accepts. Raise out_ready → all 12 words delivered in order, then done.
- Zero count: start with expected_count=0 → done two cycles later, in_ready never high, word_count=0.
- Stray/ignore: in_valid=1 in IDLE → stray=1, nothing pushed. Second start during COLLECT → ignored; expected_count unchanged. Next accepted start clears stray.
- Macro off: rerun the basic case → identical data and done timing, checksum=0 throughout.
